// File: rtl/snake_pkg.sv
// Shared constants for the snake game datapath and sequencer.
//   BIT              : pixel coordinate width
//   GS_*             : game_state encodings driven to the draw stages
//   DIR_*            : direction input encodings
//   game_state_t     : sequencer state type, encoded to match GS_*
package snake_pkg;

  localparam int BIT = 10;

  localparam logic [1:0] GS_IDLE      = 2'b00;
  localparam logic [1:0] GS_PLAY      = 2'b01;
  localparam logic [1:0] GS_GAME_OVER = 2'b11;

  localparam logic [2:0] DIR_IDLE  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b010;
  localparam logic [2:0] DIR_LEFT  = 3'b011;
  localparam logic [2:0] DIR_RIGHT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE      = GS_IDLE,
    ST_PLAY      = GS_PLAY,
    ST_GAME_OVER = GS_GAME_OVER
  } game_state_t;

  // A zero direction would put the head on top of the body, so it is not a move.
  function automatic logic is_moving(input logic [2:0] dir);
    return dir != DIR_IDLE;
  endfunction

endpackage

// File: rtl/game_control_frame_collision_monitor.sv
// Accumulates per-frame pixel overlap flags for the game sequencer.
//   clk, reset        : clock, synchronous active-high reset
//   clear             : drop all flags (frame_start or start of a game)
//   video_active      : current pixel is visible
//   snake_head_active, snake_body_active, apple_active : draw-stage coverage
//   body_hit          : head and body overlapped on a visible pixel this frame
//   head_seen         : head was drawn on at least one visible pixel this frame
//   apple_hit         : head and apple overlapped on a visible pixel this frame
module frame_collision_monitor (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic video_active,
  input  logic snake_head_active,
  input  logic snake_body_active,
  input  logic apple_active,
  output logic body_hit,
  output logic head_seen,
  output logic apple_hit
);

  // The sequencer samples the flags in the same cycle that clear is raised,
  // so clearing here loses nothing from the frame just finished.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      body_hit  <= 1'b0;
      head_seen <= 1'b0;
      apple_hit <= 1'b0;
    end else if (video_active) begin
      if (snake_head_active && snake_body_active) body_hit  <= 1'b1;
      if (snake_head_active)                      head_seen <= 1'b1;
      if (snake_head_active && apple_active)      apple_hit <= 1'b1;
    end
  end

endmodule

// File: rtl/game_control.sv
// Top-level game sequencer: drives game_state/update to the snake draw stage,
// detects body/wall/apple collisions from draw-stage activity, keeps score.
//   clk, reset        : clock, synchronous active-high reset
//   frame_start       : one-cycle pulse at start of vertical blanking
//   video_active      : current pixel visible
//   start_btn         : debounced start level (rising edge starts a game)
//   direction         : 000 idle, 001 up, 010 down, 011 left, 100 right
//   snake_head_active, snake_body_active, apple_active : draw-stage coverage
//   game_state        : 00 idle, 01 play, 11 game over
//   update            : one-cycle move tick
//   apple_eaten       : one-cycle pulse when an apple is eaten
//   score             : apples eaten this game (saturating)
module game_control
  import snake_pkg::*;
#(
  parameter int BIT             = snake_pkg::BIT,
  parameter int FRAMES_PER_STEP = 8,
  parameter int GAMEOVER_FRAMES = 120,
  parameter int SCORE_BITS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  video_active,
  input  logic                  start_btn,
  input  logic [2:0]            direction,
  input  logic                  snake_head_active,
  input  logic                  snake_body_active,
  input  logic                  apple_active,
  output logic [1:0]            game_state,
  output logic                  update,
  output logic                  apple_eaten,
  output logic [SCORE_BITS-1:0] score
);

  localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int GO_W   = (GAMEOVER_FRAMES > 1) ? $clog2(GAMEOVER_FRAMES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [GO_W-1:0]   GO_LAST   = GO_W'(GAMEOVER_FRAMES - 1);

  if (FRAMES_PER_STEP < 2 || BIT < 1) begin : g_bad_param
    $error("game_control: FRAMES_PER_STEP must be at least 2");
  end

  game_state_t           state, state_n;
  logic                  start_prev;
  logic [STEP_W-1:0]     step_cnt, step_n;
  logic [GO_W-1:0]       gameover_cnt, go_n;
  logic                  skip, skip_n;
  logic                  armed, armed_n;
  logic [SCORE_BITS-1:0] score_n;
  logic                  update_n, eaten_n;
  logic                  flag_clear;
  logic                  body_hit, head_seen, apple_hit;
  logic                  start_rise, step_wrap;

  assign start_rise = start_btn && !start_prev;
  assign step_wrap  = (step_cnt == STEP_LAST);
  assign game_state = state;

  frame_collision_monitor u_monitor (
    .clk               (clk),
    .reset             (reset),
    .clear             (flag_clear),
    .video_active      (video_active),
    .snake_head_active (snake_head_active),
    .snake_body_active (snake_body_active),
    .apple_active      (apple_active),
    .body_hit          (body_hit),
    .head_seen         (head_seen),
    .apple_hit         (apple_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      start_prev   <= 1'b0;
      step_cnt     <= '0;
      gameover_cnt <= '0;
      skip         <= 1'b0;
      armed        <= 1'b0;
      score        <= '0;
      update       <= 1'b0;
      apple_eaten  <= 1'b0;
    end else begin
      state        <= state_n;
      start_prev   <= start_btn;
      step_cnt     <= step_n;
      gameover_cnt <= go_n;
      skip         <= skip_n;
      armed        <= armed_n;
      score        <= score_n;
      update       <= update_n;
      apple_eaten  <= eaten_n;
    end
  end

  always_comb begin
    state_n    = state;
    step_n     = step_cnt;
    go_n       = gameover_cnt;
    skip_n     = skip;
    armed_n    = armed;
    score_n    = score;
    update_n   = 1'b0;
    eaten_n    = 1'b0;
    flag_clear = frame_start;

    case (state)
      ST_IDLE: begin
        // A frame_start coinciding with the start edge is simply dropped:
        // the step counter is restarted regardless.
        if (start_rise) begin
          state_n    = ST_PLAY;
          score_n    = '0;
          step_n     = '0;
          skip_n     = 1'b1;
          armed_n    = 1'b0;
          flag_clear = 1'b1;
        end
      end

      ST_PLAY: begin
        if (frame_start) begin
          step_n = step_wrap ? '0 : step_cnt + 1'b1;
          if (skip) begin
            // The first frame of a game may be partial, so its flags are
            // not trusted for collision decisions.
            skip_n = 1'b0;
            if (step_wrap && is_moving(direction)) begin
              update_n = 1'b1;
              armed_n  = 1'b1;
            end
          end else begin
            armed_n = 1'b0;
            if (body_hit || !head_seen) begin
              state_n = ST_GAME_OVER;
              go_n    = '0;
            end else begin
              // Only the frame right after a move counts as an apple hit,
              // so a lingering overlap is not scored twice.
              if (armed && apple_hit) begin
                eaten_n = 1'b1;
                if (score != '1) score_n = score + 1'b1;
              end
              if (step_wrap && is_moving(direction)) begin
                update_n = 1'b1;
                armed_n  = 1'b1;
              end
            end
          end
        end
      end

      ST_GAME_OVER: begin
        if (frame_start) begin
          if (gameover_cnt == GO_LAST) state_n = ST_IDLE;
          else                         go_n    = gameover_cnt + 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_game_control.sv
// Self-checking bench for game_control. Expected outputs come from a small
// frame-level model and are queued when stimulus is driven, then popped and
// compared once the registered response is visible.
module tb_game_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       video_active;
  logic       start_btn;
  logic [2:0] direction;
  logic       snake_head_active;
  logic       snake_body_active;
  logic       apple_active;
  logic [1:0] game_state;
  logic       update;
  logic       apple_eaten;
  logic [7:0] score;

  always #5 clk = ~clk;

  game_control #(
    .BIT             (10),
    .FRAMES_PER_STEP (8),
    .GAMEOVER_FRAMES (120),
    .SCORE_BITS      (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .frame_start       (frame_start),
    .video_active      (video_active),
    .start_btn         (start_btn),
    .direction         (direction),
    .snake_head_active (snake_head_active),
    .snake_body_active (snake_body_active),
    .apple_active      (apple_active),
    .game_state        (game_state),
    .update            (update),
    .apple_eaten       (apple_eaten),
    .score             (score)
  );

  typedef struct {
    string      tag;
    logic [1:0] state;
    logic       upd;
    logic       eat;
    logic [7:0] score;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  // Frame-level reference model
  logic [1:0] m_state;
  int         m_score;
  int         play_frames;
  int         go_frames;
  bit         m_armed;

  task automatic check_field(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic upd, input logic eat);
    exp_t e;
    e.tag   = tag;
    e.state = m_state;
    e.upd   = upd;
    e.eat   = eat;
    e.score = m_score[7:0];
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      check_field("scoreboard_empty", 8'd0, 8'd1);
    end else begin
      e = sb.pop_front();
      check_field({e.tag, ".state"}, {6'd0, game_state}, {6'd0, e.state});
      check_field({e.tag, ".update"}, {7'd0, update}, {7'd0, e.upd});
      check_field({e.tag, ".apple_eaten"}, {7'd0, apple_eaten}, {7'd0, e.eat});
      check_field({e.tag, ".score"}, score, e.score);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    m_state = 2'b00; m_score = 0; play_frames = 0; go_frames = 0; m_armed = 0;
    push_exp(tag, 1'b0, 1'b0);
    @(negedge clk);
    check_pop();
    reset = 1'b0;
  endtask

  task automatic press_start(input bit with_fs, input string tag);
    @(negedge clk);
    start_btn   = 1'b1;
    frame_start = with_fs;
    if (m_state == 2'b00) begin
      m_state = 2'b01; m_score = 0; play_frames = 0; m_armed = 0;
    end
    push_exp(tag, 1'b0, 1'b0);
    @(negedge clk);
    frame_start = 1'b0;
    check_pop();
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  // One frame: three visible pixels, the middle one (x=320,y=240) carries the
  // head and optionally body/apple; the last has body/apple away from the head.
  task automatic run_frame(input bit head, input bit body, input bit apple, input string tag);
    bit upd, eat;
    @(negedge clk);
    video_active = 1'b1;
    snake_head_active = 1'b0; snake_body_active = 1'b0; apple_active = 1'b0;
    @(negedge clk);
    snake_head_active = head; snake_body_active = body; apple_active = apple;
    @(negedge clk);
    snake_head_active = 1'b0; snake_body_active = body; apple_active = apple;
    @(negedge clk);
    video_active = 1'b0;
    snake_head_active = 1'b0; snake_body_active = 1'b0; apple_active = 1'b0;

    upd = 0; eat = 0;
    if (m_state == 2'b01) begin
      play_frames++;
      if (play_frames > 1) begin
        if ((head && body) || !head) begin
          m_state = 2'b11; go_frames = 0;
        end else begin
          if (m_armed && head && apple) begin
            eat = 1;
            if (m_score < 255) m_score++;
          end
          m_armed = 0;
          if ((play_frames % 8) == 0 && direction != 3'b000) begin
            upd = 1; m_armed = 1;
          end
        end
      end
    end else if (m_state == 2'b11) begin
      go_frames++;
      if (go_frames == 120) m_state = 2'b00;
    end

    push_exp(tag, upd, eat);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check_pop();
    push_exp({tag, ".after"}, 1'b0, 1'b0);
    @(negedge clk);
    check_pop();
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; video_active = 1'b0; start_btn = 1'b0;
    direction = 3'b000; snake_head_active = 1'b0; snake_body_active = 1'b0; apple_active = 1'b0;
    m_state = 2'b00; m_score = 0; play_frames = 0; go_frames = 0; m_armed = 0;
    repeat (2) @(negedge clk);
    push_exp("reset", 1'b0, 1'b0);
    check_pop();
    reset = 1'b0;

    $display("[TB] game 1: steps, idle direction, apple, death on wrap");
    press_start(1'b0, "start1");
    direction = 3'b100;
    for (int i = 1; i <= 24; i++) run_frame(1, 0, 0, $sformatf("right%0d", i));
    direction = 3'b000;
    for (int i = 25; i <= 56; i++) run_frame(1, 0, 0, $sformatf("still%0d", i));
    direction = 3'b100;
    for (int i = 57; i <= 64; i++) run_frame(1, 0, 0, $sformatf("right%0d", i));
    run_frame(1, 0, 1, "eat_armed");
    run_frame(1, 0, 1, "eat_unarmed");
    for (int i = 67; i <= 79; i++) run_frame(1, 0, 0, $sformatf("right%0d", i));
    run_frame(1, 1, 0, "body_hit_on_wrap");

    $display("[TB] game over hold and return to idle");
    press_start(1'b0, "start_in_gameover");
    for (int i = 1; i <= 120; i++) run_frame(0, 0, 0, $sformatf("gameover%0d", i));

    $display("[TB] game 2: score saturation, head absent");
    press_start(1'b0, "start2");
    direction = 3'b001;
    for (int i = 1; i <= 2057; i++) run_frame(1, 0, 1, $sformatf("sat%0d", i));
    run_frame(0, 0, 0, "head_absent");
    for (int i = 1; i <= 120; i++) run_frame(0, 0, 0, $sformatf("gameover2_%0d", i));

    $display("[TB] game 3: start with frame_start, skip frame, mid-play reset");
    press_start(1'b1, "start3_with_fs");
    direction = 3'b011;
    run_frame(0, 0, 0, "skip_head_absent");
    for (int i = 2; i <= 8; i++) run_frame(1, 0, 0, $sformatf("g3_%0d", i));
    run_frame(1, 0, 1, "g3_eat");
    for (int i = 10; i <= 11; i++) run_frame(1, 0, 0, $sformatf("g3_%0d", i));
    do_reset("reset_mid_play");

    $display("[TB] game 4: body hit in frame after update");
    press_start(1'b0, "start4");
    direction = 3'b010;
    for (int i = 1; i <= 8; i++) run_frame(1, 0, 0, $sformatf("g4_%0d", i));
    run_frame(1, 1, 1, "g4_body_and_apple");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
